// File: rtl/icache_fill.sv
// Direct-mapped read-only instruction cache with a single-line fill engine.
// Define ICACHE_STATS_EN to add saturating hit/miss counters.
module icache_fill #(
  parameter int unsigned LINES = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_re,
  output logic [15:0] cpu_instr,
  output logic        cpu_stall,
  input  logic        flush,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  input  logic        mem_rdy,
`ifdef ICACHE_STATS_EN
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt,
`endif
  input  logic [63:0] mem_rd_data
);

  localparam int unsigned TagW = 14 - IDX_W;

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TagW-1:0]   tag_q [LINES];
  logic [63:0]       data_q [LINES];
  logic [TagW-1:0]   miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
  logic              discard_q, discard_d;
  logic              fill_we;
  logic              hit;

  logic [1:0]        offset;
  logic [IDX_W-1:0]  index;
  logic [TagW-1:0]   tag;

  assign offset = cpu_addr[1:0];
  assign index  = cpu_addr[IDX_W+1:2];
  assign tag    = cpu_addr[15:IDX_W+2];

  assign hit       = cpu_re & valid_q[index] & (tag_q[index] == tag) & (state_q == StIdle);
  assign cpu_stall = cpu_re & ~hit;
  assign cpu_instr = hit ? data_q[index][{offset, 4'b0000} +: 16] : 16'h0000;

  // Both outputs come straight from registers so they stay stable across the handshake.
  assign mem_re   = (state_q == StFill);
  assign mem_addr = {miss_tag_q, miss_idx_q, 2'b00};

  assign fill_we = (state_q == StFill) & mem_rdy;

  always_comb begin
    state_d    = state_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    discard_d  = discard_q;
    unique case (state_q)
      StIdle: begin
        discard_d = 1'b0;
        if (cpu_re && !hit && !flush) begin
          state_d    = StFill;
          miss_tag_d = tag;
          miss_idx_d = index;
        end
      end
      StFill: begin
        if (flush) discard_d = 1'b1;
        if (mem_rdy) begin
          state_d   = StIdle;
          discard_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    // A flush seen at any point during the fill leaves the installed line invalid.
    if (fill_we) valid_d[miss_idx_q] = ~(discard_q | flush);
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      valid_q    <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      discard_q  <= discard_d;
    end
  end

  // Tag/data need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[miss_idx_q]  <= miss_tag_q;
      data_q[miss_idx_q] <= mem_rd_data;
    end
  end

`ifdef ICACHE_STATS_EN
  logic miss_start;
  assign miss_start = (state_q == StIdle) & (state_d == StFill);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (flush) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      if (miss_start && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fill.sv
// Directed self-checking bench for icache_fill: misses, hits, eviction, flush, async reset.
module tb_icache_fill;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic        cpu_re;
  logic [15:0] cpu_instr;
  logic        cpu_stall;
  logic        flush;
  logic [15:0] mem_addr;
  logic        mem_re;
  logic        mem_rdy;
  logic [63:0] mem_rd_data;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  icache_fill #(.LINES(8), .IDX_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_addr    (cpu_addr),
    .cpu_re      (cpu_re),
    .cpu_instr   (cpu_instr),
    .cpu_stall   (cpu_stall),
    .flush       (flush),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_rdy     (mem_rdy),
`ifdef ICACHE_STATS_EN
    .hit_cnt     (hit_cnt),
    .miss_cnt    (miss_cnt),
`endif
    .mem_rd_data (mem_rd_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cpu_re = 1'b0; cpu_addr = 16'h0000; flush = 1'b0;
    mem_rdy = 1'b0; mem_rd_data = '0;
    #2;
    chk("rst_mem_re", 64'(mem_re), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0000);
    chk("rst_stall_idle", 64'(cpu_stall), 64'd0);
    chk("rst_instr", 64'(cpu_instr), 64'h0000);
    #10 rst = 1'b0;

    // Cold miss on 0x0005
    tick();
    cpu_re = 1'b1; cpu_addr = 16'h0005; #1;
    chk("cold_stall", 64'(cpu_stall), 64'd1);
    chk("cold_no_req_yet", 64'(mem_re), 64'd0);
    tick();
    chk("cold_mem_re", 64'(mem_re), 64'd1);
    chk("cold_mem_addr", 64'(mem_addr), 64'h0004);
    chk("cold_instr_zero", 64'(cpu_instr), 64'h0000);
    tick();
    tick();
    mem_rdy = 1'b1; mem_rd_data = 64'h4444_3333_2222_1111; #1;
    chk("cold_stall_fill", 64'(cpu_stall), 64'd1);
    tick();
    mem_rdy = 1'b0; mem_rd_data = '0; #1;
    chk("cold_served_stall", 64'(cpu_stall), 64'd0);
    chk("cold_served_instr", 64'(cpu_instr), 64'h2222);
    chk("cold_mem_re_drop", 64'(mem_re), 64'd0);

    // Remaining words of the line
    tick(); cpu_addr = 16'h0004; #1;
    chk("hit4_instr", 64'(cpu_instr), 64'h1111);
    chk("hit4_stall", 64'(cpu_stall), 64'd0);
    tick(); cpu_addr = 16'h0006; #1;
    chk("hit6_instr", 64'(cpu_instr), 64'h3333);
    chk("hit6_mem_re", 64'(mem_re), 64'd0);
    tick(); cpu_addr = 16'h0007; #1;
    chk("hit7_instr", 64'(cpu_instr), 64'h4444);
    tick(); cpu_re = 1'b0; #1;
    chk("hits_mem_re", 64'(mem_re), 64'd0);
    chk("idle_instr_zero", 64'(cpu_instr), 64'h0000);
`ifdef ICACHE_STATS_EN
    chk("stats_hit_cnt", 64'(hit_cnt), 64'd4);
    chk("stats_miss_cnt", 64'(miss_cnt), 64'd1);
`endif

    // Conflict: 0x0024 shares index 1 with 0x0004
    cpu_re = 1'b1; cpu_addr = 16'h0024; #1;
    chk("conf_stall", 64'(cpu_stall), 64'd1);
    tick();
    chk("conf_mem_addr", 64'(mem_addr), 64'h0024);
    chk("conf_mem_re", 64'(mem_re), 64'd1);
    mem_rdy = 1'b1; mem_rd_data = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    mem_rdy = 1'b0; #1;
    chk("conf_instr", 64'(cpu_instr), 64'hDDDD);
    tick(); cpu_addr = 16'h0004; #1;
    chk("evicted_stall", 64'(cpu_stall), 64'd1);
    tick();
    chk("evicted_mem_addr", 64'(mem_addr), 64'h0004);

    // Flush while the fill for 0x0004 is outstanding
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    chk("flush_fill_holds", 64'(mem_re), 64'd1);
    mem_rdy = 1'b1; mem_rd_data = 64'h9999_8888_7777_6666;
    tick();
    mem_rdy = 1'b0; #1;
    chk("flush_idle", 64'(mem_re), 64'd0);
    chk("flush_discard_stall", 64'(cpu_stall), 64'd1);
    tick();
    chk("flush_refetch", 64'(mem_re), 64'd1);

    // Async reset mid-fill, between edges
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_re", 64'(mem_re), 64'd0);
    chk("arst_mem_addr", 64'(mem_addr), 64'h0000);
    #1 rst = 1'b0;
    #1;
    chk("arst_miss_stall", 64'(cpu_stall), 64'd1);
    tick();
    chk("arst_refill_addr", 64'(mem_addr), 64'h0004);
    mem_rdy = 1'b1; mem_rd_data = 64'h0D0D_0C0C_0B0B_0A0A;
    tick();
    mem_rdy = 1'b0; #1;
    chk("arst_refill_instr", 64'(cpu_instr), 64'h0A0A);

    // Flush coincident with mem_rdy on a fill for 0x0008
    tick(); cpu_addr = 16'h0008; #1;
    chk("coin_miss", 64'(cpu_stall), 64'd1);
    tick();
    flush = 1'b1; mem_rdy = 1'b1; mem_rd_data = 64'h1234_5678_9ABC_DEF0;
    tick();
    flush = 1'b0; mem_rdy = 1'b0; #1;
    chk("coin_discard", 64'(cpu_stall), 64'd1);
    cpu_addr = 16'h0004; #1;
    chk("coin_flushed_other", 64'(cpu_stall), 64'd1);

    // Flush in IDLE on a miss must not start a fill
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    chk("idle_flush_no_fill", 64'(mem_re), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
